// File: rtl/dds_out_pkg.sv
// Shared types and constants for the DAC output stage.
package dds_out_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FADE_OUT = 2'd1,
        MUTE     = 2'd2,
        FADE_IN  = 2'd3
    } dac_state_t;

    localparam logic [13:0] DAC_MIDSCALE = 14'h2000;
    localparam logic [2:0]  MODE_INVALID = 3'b111;
    localparam logic [7:0]  GAIN_UNITY   = 8'd128;

    // Galois LFSR for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/dac_dither_lfsr.sv
// 16-bit Galois LFSR supplying one dither bit per cycle to the DAC stage.
module dac_dither_lfsr
    import dds_out_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    output logic dith_bit
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Shift right and fold the taps back in when a one falls off the end.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    // Free-running register, reseeded on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign dith_bit = lfsr_q[0];

endmodule

// File: rtl/dac_out_stage.sv
// DAC output stage: gain with saturation, click-free fade/mute sequencing
// and conversion to offset-binary. Optional LSB dither with DAC_DITHER_EN.
module dac_out_stage
    import dds_out_pkg::*;
#(
    parameter int DW          = 14,
    parameter int FADE_LOG2   = 6,
    parameter int MUTE_CYCLES = 16
) (
    input  logic                 clk_100M,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] sample_in,
    input  logic [2:0]           mode,
    input  logic [7:0]           gain,
    input  logic                 out_en,
    output logic [DW-1:0]        dac_data,
    output logic                 busy,
    output logic                 clip
);

    localparam int FW = FADE_LOG2 + 1;
    localparam int MW = (MUTE_CYCLES > 1) ? $clog2(MUTE_CYCLES) : 1;
    localparam int GW = DW + 9;
    localparam int PW = DW + FW + 1;

    localparam logic [FW-1:0]        FADE_FULL = FW'(1 << FADE_LOG2);
    localparam logic [MW-1:0]        MUTE_LAST = MW'(MUTE_CYCLES - 1);
    localparam logic signed [GW-1:0] S_MAX     = GW'((1 << (DW - 1)) - 1);
    localparam logic signed [GW-1:0] S_MIN     = GW'(-(1 << (DW - 1)));
    localparam logic [DW-1:0]        MIDSCALE  = {1'b1, {(DW - 1){1'b0}}};

    // Apply Q1.7 gain and clamp to the signed DW-bit range; MSB of result is the clip flag.
    function automatic logic [DW:0] gain_sat(input logic signed [DW-1:0] s,
                                             input logic [7:0]           g);
        logic signed [GW-1:0] prod;
        logic signed [GW-1:0] shifted;
        logic [DW:0]          r;
        prod    = GW'(s) * GW'($signed({1'b0, g}));
        shifted = prod >>> 7;
        if (shifted > S_MAX) begin
            r = {1'b1, DW'(S_MAX)};
        end else if (shifted < S_MIN) begin
            r = {1'b1, DW'(S_MIN)};
        end else begin
            r = {1'b0, DW'(shifted)};
        end
        return r;
    endfunction

    // Scale by fade_cnt / 2**FADE_LOG2; full count is an exact pass-through.
    function automatic logic signed [DW-1:0] fade_scale(input logic signed [DW-1:0] p,
                                                        input logic [FW-1:0]        f);
        logic signed [PW-1:0] prod;
        logic signed [PW-1:0] shifted;
        prod    = PW'(p) * PW'($signed({1'b0, f}));
        shifted = prod >>> FADE_LOG2;
        return DW'(shifted);
    endfunction

    // Two's-complement to offset-binary: flip the sign bit.
    function automatic logic [DW-1:0] to_offset(input logic signed [DW-1:0] q);
        return {~q[DW-1], q[DW-2:0]};
    endfunction

`ifdef DAC_DITHER_EN
    // Add one LSB of dither, clamping at the top code.
    function automatic logic [DW-1:0] dither_add(input logic [DW-1:0] w, input logic b);
        logic [DW-1:0] r;
        if (b && (w == {DW{1'b1}})) begin
            r = w;
        end else begin
            r = w + DW'(b);
        end
        return r;
    endfunction
`endif

    // Pipeline state (data path is not reset; control and output word are).
    logic signed [DW-1:0] samp_p0_q, samp_p0_d;
    logic signed [DW-1:0] gsamp_p1_q, gsamp_p1_d;
    logic                 clip_p1_q, clip_p1_d;
    logic [DW-1:0]        dac_data_q, dac_data_d;
    logic                 clip_p2_q, clip_p2_d;

    // Sequencer state.
    dac_state_t    state_q, state_d;
    logic [FW-1:0] fade_cnt_q, fade_cnt_d;
    logic [MW-1:0] mute_cnt_q, mute_cnt_d;
    logic [2:0]    mode_q, mode_d;
    logic          busy_q, busy_d;

    logic          trig;
    logic [DW:0]   gsat;
    logic signed [DW-1:0] scaled;
    logic [DW-1:0] off_word;

`ifdef DAC_DITHER_EN
    logic dith_bit;

    dac_dither_lfsr u_dither (
        .clk      (clk_100M),
        .rst_n    (rst_n),
        .dith_bit (dith_bit)
    );
`endif

    assign trig = (mode != mode_q) | ~out_en | (mode == MODE_INVALID);

    // Stage boundaries: S1 capture, S2 gain/saturate, S3 fade scale and offset conversion.
    always_comb begin
        samp_p0_d  = sample_in;
        gsat       = gain_sat(samp_p0_q, gain);
        gsamp_p1_d = $signed(gsat[DW-1:0]);
        clip_p1_d  = gsat[DW];
        scaled     = fade_scale(gsamp_p1_q, fade_cnt_q);
        off_word   = to_offset(scaled);
`ifdef DAC_DITHER_EN
        dac_data_d = dither_add(off_word, dith_bit && (fade_cnt_q != '0));
`else
        dac_data_d = off_word;
`endif
        clip_p2_d  = clip_p1_q;
    end

    // Fade/mute sequencer: next state and counters; busy tracks the state one cycle late.
    always_comb begin
        state_d    = state_q;
        fade_cnt_d = fade_cnt_q;
        mute_cnt_d = mute_cnt_q;
        mode_d     = mode;
        busy_d     = (state_q != RUN);
        case (state_q)
            RUN: begin
                if (trig) begin
                    state_d = FADE_OUT;
                end
            end
            FADE_OUT: begin
                if (fade_cnt_q <= FW'(1)) begin
                    fade_cnt_d = '0;
                    mute_cnt_d = '0;
                    state_d    = MUTE;
                end else begin
                    fade_cnt_d = fade_cnt_q - FW'(1);
                end
            end
            MUTE: begin
                if (trig) begin
                    mute_cnt_d = '0;
                end else if (mute_cnt_q >= MUTE_LAST) begin
                    mute_cnt_d = '0;
                    state_d    = FADE_IN;
                end else begin
                    mute_cnt_d = mute_cnt_q + MW'(1);
                end
            end
            FADE_IN: begin
                if (trig) begin
                    state_d = FADE_OUT;
                end else if (fade_cnt_q >= (FADE_FULL - FW'(1))) begin
                    fade_cnt_d = FADE_FULL;
                    state_d    = RUN;
                end else begin
                    fade_cnt_d = fade_cnt_q + FW'(1);
                end
            end
            default: begin
                state_d = MUTE;
            end
        endcase
    end

    // S1/S2 data registers.
    always_ff @(posedge clk_100M) begin
        samp_p0_q  <= samp_p0_d;
        gsamp_p1_q <= gsamp_p1_d;
    end

    // Control, clip flags and the S3 output word; reset parks the DAC at midscale.
    always_ff @(posedge clk_100M) begin
        if (!rst_n) begin
            state_q    <= MUTE;
            fade_cnt_q <= '0;
            mute_cnt_q <= '0;
            mode_q     <= mode;
            busy_q     <= 1'b1;
            clip_p1_q  <= 1'b0;
            clip_p2_q  <= 1'b0;
            dac_data_q <= MIDSCALE;
        end else begin
            state_q    <= state_d;
            fade_cnt_q <= fade_cnt_d;
            mute_cnt_q <= mute_cnt_d;
            mode_q     <= mode_d;
            busy_q     <= busy_d;
            clip_p1_q  <= clip_p1_d;
            clip_p2_q  <= clip_p2_d;
            dac_data_q <= dac_data_d;
        end
    end

    assign dac_data = dac_data_q;
    assign busy     = busy_q;
    assign clip     = clip_p2_q;

endmodule
